ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Single-core memory responder for the cache subsystem. It accepts word requests from the instruction cache (read-only) and the data cache (read/write), arbitrates between them, and drives one shared RAM port. It acknowledges each request by dropping the requester's wait line for exactly one cycle. It is the controller end of the cache/controller handshake the caches issue (dREN/dWEN/daddr/dstore, iREN/iaddr), and sits between the caches and the RAM model.

## Interface
- `DSTREAK_MAX`, default 4: maximum number of consecutive data grants allowed while an instruction request is pending.
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `iREN` in 1: icache read request.
- `iaddr` in 32: icache word address.
- `iwait` out 1: icache wait; low for one cycle means `iload` is valid.
- `iload` out 32: icache read data.
- `dREN` in 1: dcache read request.
- `dWEN` in 1: dcache write request.
- `daddr` in 32: dcache word address.
- `dstore` in 32: dcache write data.
- `dwait` out 1: dcache wait; low for one cycle means the access completed.
- `dload` out 32: dcache read data.
- `ramREN` out 1: RAM read strobe.
- `ramWEN` out 1: RAM write strobe.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data.
- `ramstate` in 2 (`ramstate_t`): FREE, BUSY, ACCESS, ERROR.
- `err_count` out 8: saturating count of ERROR cycles seen.

## Operation
- States: IDLE, DACC, IACC.
- IDLE:
  - If `dREN|dWEN` and (`iREN`==0 or streak<`DSTREAK_MAX`), go to DACC.
  - Else if `iREN`, go to IACC and clear the streak.
  - Else stay in IDLE.
- In IDLE, all RAM strobes are 0, `ramaddr`/`ramstore` are 0, and both waits are 1.
- DACC:
  - `ramaddr`=`daddr`.
  - `ramWEN`=`dWEN`; `ramREN`=`dREN & !dWEN` (write wins when both are set).
  - `ramstore`=`dstore`.
  - Inputs are live, not latched.
- IACC: `ramREN`=1, `ramaddr`=`iaddr`, `ramWEN`=0.
- Completion: in DACC/IACC with `ramstate`==ACCESS:
  - The granted wait goes 0 combinationally that cycle.
  - `dload`/`iload`=`ramload` that cycle.
  - Next state is IDLE.
  - A DACC completion increments the streak, saturating at `DSTREAK_MAX`.
- BUSY/FREE: remain in the grant state with strobes held.
- ERROR: treated as BUSY (retry). `err_count` increments, saturating at 255.
- Abort: in DACC with `dREN|dWEN`==0 (or IACC with `iREN`==0), return to IDLE next cycle. No wait pulse, streak unchanged.
- An instruction grant or an IDLE cycle with no `dREN|dWEN` clears the streak.
- `dload`/`iload` are 0 whenever their wait is 1.

## Timing
- Reset values: state IDLE, `iwait`=`dwait`=1, all RAM outputs 0, `iload`=`dload`=0, streak 0, `err_count` 0.
- Reset mid-access abandons the access immediately (asynchronous). The RAM strobes drop with reset.
- Request latency:
  - Request seen in IDLE at cycle N.
  - Grant state and RAM strobes start at cycle N+1.
  - The wait pulse falls on the first cycle ≥N+1 with ACCESS.
  - Return to IDLE at the following cycle.
- Minimum of 2 cycles per word. A back-to-back request from the same cache is re-arbitrated in IDLE.
- Wait pulse width is exactly one cycle per completed word.
- Requesters must hold request, address and data stable until their wait pulse. Changes mid-access pass straight through to the RAM.
- Simultaneous d and i requests in IDLE: data wins unless streak==`DSTREAK_MAX`.

## Structure
- `ramstate_t` and `word_t` come from `cpu_types_pkg`.
- The arbiter state enum is added to `cpu_types_pkg` as `arbstate_t`.
- Streak counter width is `$clog2(DSTREAK_MAX+1)`.
- Single module, no sub-module. The RAM model is instantiated only in the bench.

## Test plan
- Data read, RAM latency 2:
  - Stimulus: `dREN`=1, `daddr`=0x40, `ramload`=0xDEADBEEF.
  - Response: `ramREN`=1 from cycle 1, `dwait`=0 and `dload`=0xDEADBEEF at cycle 3 only, IDLE at cycle 4.
- Simultaneous requests:
  - Stimulus: `dWEN`=1 (`daddr`=0x80, `dstore`=0x1234) and `iREN`=1 (`iaddr`=0x0), latency 0.
  - Response: the data write completes first (`ramWEN`=1, `ramstore`=0x1234). The instruction read is granted in the next arbitration.
- Starvation guard:
  - Stimulus: `dREN` and `iREN` held constantly, latency 0, `DSTREAK_MAX`=4.
  - Response: 4 `dwait` pulses, then 1 `iwait` pulse, repeating.
- Read/write conflict:
  - Stimulus: `dREN`=`dWEN`=1.
  - Response: `ramWEN`=1, `ramREN`=0.
- Abort:
  - Stimulus: `dREN` deasserted while `ramstate`=BUSY.
  - Response: no `dwait` pulse, IDLE next cycle, strobes 0.
- ERROR then reset:
  - Stimulus: 3 ERROR cycles, then ACCESS.
  - Response: `err_count`=3 and the access completes.
  - Stimulus: `nRST` asserted mid-BUSY.
  - Response: all outputs return to reset values immediately.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/memory subsystem: RAM port status, the data word
// and the state encoding of the RAM arbiter.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } arbstate_t;

endpackage

// File: rtl/ram_arbiter.sv
// Arbitrates icache (read-only) and dcache (read/write) word requests onto one
// RAM port, with a streak limit so a busy dcache cannot starve the icache.
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int DSTREAK_MAX = 4
) (
    input  logic      CLK,
    input  logic      nRST,
    // icache side
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    // dcache side
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    // RAM side
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    // status / debug
    output logic [7:0] err_count,
    output arbstate_t  dbg_state
);

    localparam int SW = $clog2(DSTREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(DSTREAK_MAX);

    // Handshake: a requester raises its request with address/data and holds them
    // stable; the arbiter acknowledges by driving that requester's wait low for
    // exactly one cycle, during which the load data is valid. Dropping the
    // request before the acknowledge abandons the access without a pulse.

    arbstate_t       state_q, state_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic [7:0]      err_q, err_d;
    logic            d_req;

    assign d_req     = dREN | dWEN;
    assign err_count = err_q;
    assign dbg_state = state_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            streak_q <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        err_d    = err_q;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;

        case (state_q)
            IDLE: begin
                if (d_req && (!iREN || (streak_q < STREAK_MAX))) begin
                    state_d = DACC;
                end else begin
                    // Either nothing from the dcache or the icache takes its turn.
                    streak_d = '0;
                    if (iREN) state_d = IACC;
                end
            end
            DACC: begin
                ramaddr  = daddr;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramstore = dstore;
                if (!d_req) begin
                    state_d = IDLE;
                end else if (ramstate == ACCESS) begin
                    dwait   = 1'b0;
                    dload   = ramload;
                    state_d = IDLE;
                    if (streak_q < STREAK_MAX) streak_d = streak_q + SW'(1);
                end
            end
            IACC: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ramstate == ACCESS) begin
                    iwait   = 1'b0;
                    iload   = ramload;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // ERROR is simply retried like BUSY; only the counter notices it.
        if ((state_q != IDLE) && (ramstate == ERROR) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a RAM model with programmable latency/errors, cache
// drivers pushing expected responses, and a monitor that checks every wait pulse.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int DSTREAK_MAX = 4;
  localparam int TIMEOUT = 200;

  logic CLK = 1'b0;
  logic nRST;
  logic iREN, dREN, dWEN;
  word_t iaddr, daddr, dstore;
  logic iwait, dwait;
  word_t iload, dload;
  logic ramREN, ramWEN;
  word_t ramaddr, ramstore, ramload;
  ramstate_t ramstate;
  logic [7:0] err_count;
  arbstate_t dbg_state;

  ram_arbiter #(.DSTREAK_MAX(DSTREAK_MAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .err_count(err_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // ---------------- memory contents ----------------
  function automatic word_t init_word(input logic [8:0] a);
    if (a == 9'h040) return 32'hDEADBEEF;
    return {7'h5A, a, 7'h33, a};
  endfunction

  // RAM model: word memory, latency counted from the first strobe cycle,
  // optional ERROR cycles injected at the start of an access.
  word_t ram_mem [0:511];
  bit    ram_written [0:511];
  int    wait_cnt, errs_left, rnd_lat, err_seen;
  int    fixed_lat = 0;
  int    inject_errs = 0;
  bit    rand_ram = 0;
  int    lat;

  assign lat = rand_ram ? rnd_lat : fixed_lat;
  assign ramload = ram_written[ramaddr[8:0]] ? ram_mem[ramaddr[8:0]] : init_word(ramaddr[8:0]);

  always_comb begin
    if (!(ramREN || ramWEN))  ramstate = FREE;
    else if (errs_left > 0)   ramstate = ERROR;
    else if (wait_cnt >= lat) ramstate = ACCESS;
    else                      ramstate = BUSY;
  end

  always @(posedge CLK) begin
    if (!(ramREN || ramWEN)) begin
      wait_cnt  <= 0;
      errs_left <= rand_ram ? (($urandom_range(0, 4) == 0) ? 1 : 0) : inject_errs;
      rnd_lat   <= $urandom_range(0, 3);
    end else if (ramstate == ERROR) begin
      errs_left <= errs_left - 1;
    end else if (ramstate == ACCESS) begin
      wait_cnt <= 0;
      if (ramWEN) begin
        ram_mem[ramaddr[8:0]]     <= ramstore;
        ram_written[ramaddr[8:0]] <= 1'b1;
      end
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) err_seen <= 0;
    else if (ramstate == ERROR) err_seen <= err_seen + 1;
  end

  // ---------------- reference memory and expected queues ----------------
  word_t ref_mem [0:511];
  bit    ref_written [0:511];

  typedef struct packed {
    logic  is_write;
    word_t addr;
    word_t wdata;
    word_t rdata;
  } d_exp_t;

  d_exp_t      d_exp_q[$];
  logic [63:0] i_exp_q[$];
  byte         pulse_log[$];

  function automatic word_t ref_read(input word_t a);
    return ref_written[a[8:0]] ? ref_mem[a[8:0]] : init_word(a[8:0]);
  endfunction

  function automatic d_exp_t d_expect(input bit wr, input word_t a, input word_t wd);
    d_exp_t e;
    e.is_write = wr;
    e.addr     = a;
    e.wdata    = wd;
    e.rdata    = ref_read(a);
    if (wr) begin
      ref_mem[a[8:0]]     = wd;
      ref_written[a[8:0]] = 1'b1;
    end
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic d_txn(input bit rd, input bit wr, input word_t a, input word_t wd);
    int n = 0;
    bit seen = 0;
    d_exp_q.push_back(d_expect(wr, a, wd));
    dREN = rd; dWEN = wr; daddr = a; dstore = wd;
    while (!seen && n < TIMEOUT) begin
      @(negedge CLK);
      n++;
      if (!dwait) seen = 1;
    end
    check("d_complete", seen, 1);
    @(posedge CLK);
    #1;
    dREN = 1'b0; dWEN = 1'b0;
  endtask

  task automatic i_txn(input word_t a);
    int n = 0;
    bit seen = 0;
    i_exp_q.push_back({a, ref_read(a)});
    iREN = 1'b1; iaddr = a;
    while (!seen && n < TIMEOUT) begin
      @(negedge CLK);
      n++;
      if (!iwait) seen = 1;
    end
    check("i_complete", seen, 1);
    @(posedge CLK);
    #1;
    iREN = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit d_low_prev, i_low_prev;
  int d_while_i;

  always @(negedge CLK) begin
    if (!nRST) begin
      d_low_prev = 0; i_low_prev = 0; d_while_i = 0;
    end else begin
      if (dwait) check("dload_zero", dload, 0);
      if (iwait) check("iload_zero", iload, 0);
      if (!dwait) begin
        d_exp_t e;
        check("dwait_width", d_low_prev, 0);
        pulse_log.push_back(8'd1);
        if (iREN) d_while_i++;
        if (d_exp_q.size() == 0) begin
          check("d_unexpected_pulse", 1, 0);
        end else begin
          e = d_exp_q.pop_front();
          check("d_ramaddr", ramaddr, e.addr);
          check("d_ramWEN", ramWEN, e.is_write);
          check("d_ramREN", ramREN, !e.is_write);
          check("d_dload", dload, e.rdata);
          if (e.is_write) check("d_ramstore", ramstore, e.wdata);
        end
      end
      if (!iwait) begin
        logic [63:0] ie;
        check("iwait_width", i_low_prev, 0);
        check("i_starvation", d_while_i <= DSTREAK_MAX, 1);
        d_while_i = 0;
        pulse_log.push_back(8'd2);
        if (i_exp_q.size() == 0) begin
          check("i_unexpected_pulse", 1, 0);
        end else begin
          ie = i_exp_q.pop_front();
          check("i_ramaddr", ramaddr, ie[63:32]);
          check("i_ramREN", ramREN, 1);
          check("i_ramWEN", ramWEN, 0);
          check("i_iload", iload, ie[31:0]);
        end
      end
      if (!iREN) d_while_i = 0;
      d_low_prev = !dwait;
      i_low_prev = !iwait;
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_iwait"}, iwait, 1);
    check({tag, "_dwait"}, dwait, 1);
    check({tag, "_ramREN"}, ramREN, 0);
    check({tag, "_ramWEN"}, ramWEN, 0);
    check({tag, "_ramaddr"}, ramaddr, 0);
    check({tag, "_ramstore"}, ramstore, 0);
    check({tag, "_iload"}, iload, 0);
    check({tag, "_dload"}, dload, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  initial begin
    nRST = 1'b0;
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    #2;
    check_reset_outputs("rst");
    do_reset();

    // Data read, latency 2: strobe from cycle 1, acknowledge at cycle 3 only.
    fixed_lat = 2;
    fork
      d_txn(1, 0, 32'h40, 32'h0);
      begin
        @(negedge CLK); check("t1_c0_ramREN", ramREN, 0);
        @(negedge CLK); check("t1_c1_ramREN", ramREN, 1);
        check("t1_c1_ramaddr", ramaddr, 32'h40); check("t1_c1_dwait", dwait, 1);
        @(negedge CLK); check("t1_c2_dwait", dwait, 1);
        @(negedge CLK); check("t1_c3_dwait", dwait, 0);
        check("t1_c3_dload", dload, 32'hDEADBEEF);
        @(negedge CLK); check("t1_c4_state", dbg_state, IDLE);
        check("t1_c4_dwait", dwait, 1);
      end
    join
    @(posedge CLK); #1;

    // Simultaneous write and instruction fetch: data first.
    do_reset();
    fixed_lat = 0;
    pulse_log.delete();
    fork
      d_txn(0, 1, 32'h80, 32'h1234);
      i_txn(32'h0);
    join
    check("t2_pulses", pulse_log.size(), 2);
    if (pulse_log.size() == 2) begin
      check("t2_first_d", pulse_log[0], 1);
      check("t2_second_i", pulse_log[1], 2);
    end

    // Starvation guard: both requests held, 4 data words then 1 instruction.
    do_reset();
    pulse_log.delete();
    for (int k = 0; k < 8; k++) d_exp_q.push_back(d_expect(0, 32'h104, 32'h0));
    for (int k = 0; k < 2; k++) i_exp_q.push_back({32'h8, ref_read(32'h8)});
    dREN = 1; daddr = 32'h104; iREN = 1; iaddr = 32'h8;
    for (int n = 0; n < TIMEOUT; n++) begin
      @(posedge CLK);
      if (pulse_log.size() >= 10) break;
    end
    #1;
    dREN = 0; iREN = 0;
    check("t3_pulses", pulse_log.size(), 10);
    for (int j = 0; j < pulse_log.size() && j < 10; j++)
      check("t3_sequence", pulse_log[j], (j % 5 == 4) ? 2 : 1);
    repeat (2) @(posedge CLK); #1;

    // Read and write asserted together: the write wins.
    d_txn(1, 1, 32'h108, 32'hCAFE0001);

    // Abort while BUSY: no acknowledge, back to IDLE.
    fixed_lat = 10;
    dREN = 1; daddr = 32'h10C;
    repeat (3) @(posedge CLK);
    #1;
    dREN = 0;
    @(negedge CLK);
    check("t5_abort_ramREN", ramREN, 0);
    check("t5_abort_dwait", dwait, 1);
    @(negedge CLK);
    check("t5_idle_state", dbg_state, IDLE);
    check("t5_idle_dwait", dwait, 1);
    @(posedge CLK); #1;

    // Three ERROR cycles are retried, counted, then the access completes.
    do_reset();
    fixed_lat = 0;
    inject_errs = 3;
    d_txn(1, 0, 32'h110, 32'h0);
    inject_errs = 0;
    @(negedge CLK);
    check("t6_err_count", err_count, 3);

    // Reset asserted mid-access returns every output to reset values at once.
    @(posedge CLK); #1;
    fixed_lat = 20;
    iREN = 1; iaddr = 32'h10;
    repeat (3) @(posedge CLK);
    #2;
    check("t6_busy_ramREN", ramREN, 1);
    nRST = 1'b0;
    #1;
    check_reset_outputs("midrst");
    iREN = 0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Randomized traffic from both caches against a random-latency RAM.
    fixed_lat = 0;
    rand_ram = 1;
    fork
      for (int k = 0; k < 40; k++) begin
        int op;
        repeat ($urandom_range(0, 2)) @(posedge CLK);
        #1;
        op = $urandom_range(0, 2);
        d_txn(op != 1, op != 0, 32'h100 + $urandom_range(0, 31), $urandom());
      end
      for (int k = 0; k < 40; k++) begin
        repeat ($urandom_range(0, 2)) @(posedge CLK);
        #1;
        i_txn($urandom_range(0, 63));
      end
    join
    rand_ram = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rand_err_count", err_count, (err_seen > 255) ? 255 : err_seen);
    check("d_queue_empty", d_exp_q.size(), 0);
    check("i_queue_empty", i_exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
